game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Top-level game controller for the falling-tile rhythm game.
- Generates the 60 Hz frame tick and a gated play tick that drives the four lane columns.
- Schedules tile spawns per lane using an LFSR, with a difficulty ramp driven by hits.
- Tracks lives from lane miss pulses and runs the IDLE/COUNTDOWN/PLAY/PAUSE/OVER game-flow FSM that the renderer and score logic key off.

Parameters:
- FRAME_DIV, 833333: clk cycles per frame (50 MHz / 60 Hz).
- COUNTDOWN_FRAMES, 180: frames in the pre-play countdown.
- SPAWN_START, 60: initial frames between spawns.
- SPAWN_MIN, 20: floor on the spawn interval.
- SPAWN_STEP, 5: interval reduction per level.
- LEVEL_HITS, 10: hits needed per level-up.
- LIVES, 5: starting lives (max 7).
- LFSR_SEED, 8'hA5: LFSR reset/reload value (nonzero).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start_btn  in  1  start/restart button level, pre-synchronised.
- pause_btn  in  1  pause toggle level, pre-synchronised.
- hit  in  4  per-lane hit pulses (1 clk each) from the columns.
- miss  in  4  per-lane miss pulses (1 clk each) from the columns.
- frame_tick  out  1  free-running 1-clk pulse every FRAME_DIV cycles.
- play_tick  out  1  frame_tick gated by state==PLAY; drives column motion.
- spawn  out  4  one-hot 1-clk spawn request, bit n = lane n.
- state  out  3  0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 PAUSE, 4 OVER.
- game_active  out  1  high only in PLAY.
- level  out  4  current level, saturates at 15.
- lives_left  out  3  remaining lives.
- spawn_interval  out  8  current frames per spawn.
- countdown_sec  out  2  countdown digit for display: 3, 2, 1, else 0.

Behaviour:
- Reset state: all regs cleared. state=IDLE, frame counter=0, frame_tick=play_tick=0, spawn=0, level=0, lives_left=LIVES, spawn_interval=SPAWN_START, countdown=0, hit_count=0, spawn timer=0, lfsr=LFSR_SEED, button prev regs=0.
- Frame divider: counts 0..FRAME_DIV-1 and wraps; frame_tick=1 in the cycle after the counter equals FRAME_DIV-1. It runs in every state.
- Edge detect: start_e = start_btn & ~prev, pause_e = pause_btn & ~prev; 1-cycle registered prev. A held button yields exactly one event.
- IDLE: on start_e go to COUNTDOWN; countdown=COUNTDOWN_FRAMES.
- COUNTDOWN: countdown decrements on frame_tick. On a frame_tick with countdown==1, go to PLAY with spawn timer=0. countdown_sec = 3 if cnt>120, 2 if cnt>60, 1 if cnt>0, else 0. pause_e and start_e are ignored.
- PLAY, spawn scheduling:
  - Spawn timer increments on frame_tick.
  - On a frame_tick with timer==spawn_interval-1: timer=0, spawn[lfsr[1:0]]=1 for exactly the next clk, then lfsr advances one step (Fibonacci, taps 8,6,5,4; feedback into bit0).
  - LFSR changes only on spawn.
- PLAY, hits:
  - Per cycle, hit_count += popcount(hit).
  - If the result is >= LEVEL_HITS: hit_count -= LEVEL_HITS, level+1 (saturating at 15), spawn_interval = max(SPAWN_MIN, spawn_interval-SPAWN_STEP), all in the same cycle.
  - A new interval takes effect at the next timer compare. If the timer already exceeds the new interval-1, spawn on the next frame_tick.
- PLAY, misses:
  - lives_left -= popcount(miss), saturating at 0.
  - If the result is 0, go to OVER next cycle.
- PLAY, pause: pause_e goes to PAUSE.
- Simultaneous events in PLAY:
  - hit and miss in the same cycle: both applied.
  - lives reaching 0 and pause_e in the same cycle: OVER wins.
  - Any spawn due in the cycle lives hit 0 is suppressed.
- PAUSE:
  - Spawn timer, countdown and play_tick are frozen; no spawns; hit/miss ignored.
  - pause_e returns to PLAY with the timer value preserved. start_e is ignored.
- OVER:
  - game_active=0, no spawns; level/lives/interval hold for display.
  - start_e re-initialises lives, level, interval, hit_count, timer and lfsr=LFSR_SEED, then goes to COUNTDOWN.
- Illegal state encodings (5-7) go to IDLE next cycle.
- spawn is never multi-hot. play_tick never asserts outside PLAY.
- Reset asserted mid-operation forces the reset values immediately; spawn deasserts asynchronously.

Test Plan:
Use FRAME_DIV=4 for all scenarios.
- Reset check: assert reset mid-PLAY with spawn pending -> next cycle all outputs at reset values, state=0, lives_left=5, spawn=0.
- Start and countdown: start_btn held 20 cycles in IDLE -> single COUNTDOWN entry. countdown_sec reads 3, then 2, then 1; PLAY after exactly 180 frame_ticks. play_tick stays 0 until PLAY.
- Spawn cadence: in PLAY, the first spawn comes 60 frame_ticks after entry on lane 1 (0xA5[1:0]=01), then on lane lfsr'[1:0]. Spacing is 60 frames; spawn is one-hot and 1 clk wide.
- Level ramp: 10 hit pulses, including one cycle with hit=4'b0011 -> level=1, spawn_interval=55. After 8 level-ups the interval stays at 20 and level keeps counting.
- Lives and OVER: miss pulses totalling 5, the last as miss=4'b0110 with lives=2 plus pause_btn edge in the same cycle -> lives_left=0, state=OVER (not PAUSE), no spawn. A following start edge gives COUNTDOWN, lives=5, level=0, interval=60.
- Pause: pause edge at timer=30 -> play_tick=0, no spawns, hit/miss ignored for 100 frames. Second pause edge -> PLAY; next spawn after 30 more frames.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: frame timing, lane spawn scheduling, lives and the
// IDLE/COUNTDOWN/PLAY/PAUSE/OVER game-flow FSM for the falling-tile game.

module game_sequencer #(
  parameter int         FRAME_DIV        = 833333,
  parameter int         COUNTDOWN_FRAMES = 180,
  parameter int         SPAWN_START      = 60,
  parameter int         SPAWN_MIN        = 20,
  parameter int         SPAWN_STEP       = 5,
  parameter int         LEVEL_HITS       = 10,
  parameter int         LIVES            = 5,
  parameter logic [7:0] LFSR_SEED        = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic [3:0] hit,
  input  logic [3:0] miss,
  output logic       frame_tick,
  output logic       play_tick,
  output logic [3:0] spawn,
  output logic [2:0] state,
  output logic       game_active,
  output logic [3:0] level,
  output logic [2:0] lives_left,
  output logic [7:0] spawn_interval,
  output logic [1:0] countdown_sec
);

  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FW-1:0] L_FMAX = FW'(FRAME_DIV - 1);
  localparam logic [7:0] L_CD    = 8'(COUNTDOWN_FRAMES);
  localparam logic [7:0] L_START = 8'(SPAWN_START);
  localparam logic [7:0] L_MIN   = 8'(SPAWN_MIN);
  localparam logic [7:0] L_STEP  = 8'(SPAWN_STEP);
  localparam logic [7:0] L_DROP  = 8'(SPAWN_MIN + SPAWN_STEP);
  localparam logic [7:0] L_LVH   = 8'(LEVEL_HITS);
  localparam logic [2:0] L_LIVES = 3'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CD    = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [FW-1:0]   r_fcnt;
  logic            r_ftick;
  logic            r_start_q;
  logic            r_pause_q;
  logic [7:0]      r_cd;
  logic [7:0]      r_timer;
  logic [7:0]      r_interval;
  logic [3:0]      r_level;
  logic [2:0]      r_lives;
  logic [7:0]      r_hits;
  logic [7:0]      r_lfsr;
  logic [3:0]      r_spawn;

  logic            w_start_e;
  logic            w_pause_e;
  logic [2:0]      w_hpop;
  logic [2:0]      w_mpop;
  logic [7:0]      w_hsum;
  logic            w_lvl_up;
  logic            w_over;
  logic            w_due;
  logic [7:0]      w_lfsr_n;

  assign w_start_e = start_btn & ~r_start_q;
  assign w_pause_e = pause_btn & ~r_pause_q;
  assign w_hpop    = 3'(hit[0]) + 3'(hit[1]) + 3'(hit[2]) + 3'(hit[3]);
  assign w_mpop    = 3'(miss[0]) + 3'(miss[1]) + 3'(miss[2]) + 3'(miss[3]);
  assign w_hsum    = r_hits + 8'(w_hpop);
  assign w_lvl_up  = (w_hsum >= L_LVH);
  assign w_over    = (r_state == S_PLAY) && (w_mpop != 3'd0) &&
                     (w_mpop >= r_lives);
  assign w_due     = r_ftick && (r_timer >= r_interval - 8'd1);
  assign w_lfsr_n  = {r_lfsr[6:0],
                      r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  // Free-running frame divider; tick lands the cycle after the wrap value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fcnt  <= '0;
      r_ftick <= 1'b0;
    end else begin
      r_ftick <= (r_fcnt == L_FMAX);
      r_fcnt  <= (r_fcnt == L_FMAX) ? '0 : r_fcnt + FW'(1);
    end
  end

  // Previous button levels for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_q <= 1'b0;
      r_pause_q <= 1'b0;
    end else begin
      r_start_q <= start_btn;
      r_pause_q <= pause_btn;
    end
  end

  // Game-flow state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  // Next-state logic; running out of lives beats a same-cycle pause.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (w_start_e) w_state_n = S_CD;
      S_CD:    if (r_ftick && r_cd == 8'd1) w_state_n = S_PLAY;
      S_PLAY: begin
        if (w_over)         w_state_n = S_OVER;
        else if (w_pause_e) w_state_n = S_PAUSE;
      end
      S_PAUSE: if (w_pause_e) w_state_n = S_PLAY;
      S_OVER:  if (w_start_e) w_state_n = S_CD;
      default: w_state_n = S_IDLE;
    endcase
  end

  // Countdown, spawn timer, difficulty, lives and LFSR datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cd       <= 8'd0;
      r_timer    <= 8'd0;
      r_interval <= L_START;
      r_level    <= 4'd0;
      r_lives    <= L_LIVES;
      r_hits     <= 8'd0;
      r_lfsr     <= LFSR_SEED;
      r_spawn    <= 4'd0;
    end else begin
      r_spawn <= 4'd0;
      case (r_state)
        S_IDLE: if (w_start_e) r_cd <= L_CD;
        S_CD: begin
          if (r_ftick) begin
            r_cd <= r_cd - 8'd1;
            if (r_cd == 8'd1) r_timer <= 8'd0;
          end
        end
        S_PLAY: begin
          if (w_lvl_up) begin
            r_hits     <= w_hsum - L_LVH;
            r_level    <= (r_level == 4'd15) ? r_level : r_level + 4'd1;
            r_interval <= (r_interval >= L_DROP) ? r_interval - L_STEP
                                                 : L_MIN;
          end else begin
            r_hits <= w_hsum;
          end
          r_lives <= w_over ? 3'd0 : r_lives - w_mpop;
          if (w_due) begin
            r_timer <= 8'd0;
            if (!w_over) begin
              r_spawn <= 4'b0001 << r_lfsr[1:0];
              r_lfsr  <= w_lfsr_n;
            end
          end else if (r_ftick) begin
            r_timer <= r_timer + 8'd1;
          end
        end
        S_OVER: begin
          if (w_start_e) begin
            r_cd       <= L_CD;
            r_timer    <= 8'd0;
            r_interval <= L_START;
            r_level    <= 4'd0;
            r_lives    <= L_LIVES;
            r_hits     <= 8'd0;
            r_lfsr     <= LFSR_SEED;
          end
        end
        default: ;
      endcase
    end
  end

  // Countdown digit shown while the pre-play counter runs.
  always_comb begin
    if (r_cd > 8'd120)     countdown_sec = 2'd3;
    else if (r_cd > 8'd60) countdown_sec = 2'd2;
    else if (r_cd > 8'd0)  countdown_sec = 2'd1;
    else                   countdown_sec = 2'd0;
  end

  assign frame_tick     = r_ftick;
  assign play_tick      = r_ftick && (r_state == S_PLAY);
  assign spawn          = r_spawn;
  assign state          = r_state;
  assign game_active    = (r_state == S_PLAY);
  assign level          = r_level;
  assign lives_left     = r_lives;
  assign spawn_interval = r_interval;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed scenarios for game_sequencer with a
// 4-cycle frame so whole games fit in a few thousand cycles.

module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn;
  logic       pause_btn;
  logic [3:0] hit;
  logic [3:0] miss;
  logic       frame_tick;
  logic       play_tick;
  logic [3:0] spawn;
  logic [2:0] state;
  logic       game_active;
  logic [3:0] level;
  logic [2:0] lives_left;
  logic [7:0] spawn_interval;
  logic [1:0] countdown_sec;

  int n_cmp = 0;
  int n_bad = 0;
  int mon_bad = 0;

  game_sequencer #(.FRAME_DIV(4)) dut (
    .clk(clk),
    .reset(reset),
    .start_btn(start_btn),
    .pause_btn(pause_btn),
    .hit(hit),
    .miss(miss),
    .frame_tick(frame_tick),
    .play_tick(play_tick),
    .spawn(spawn),
    .state(state),
    .game_active(game_active),
    .level(level),
    .lives_left(lives_left),
    .spawn_interval(spawn_interval),
    .countdown_sec(countdown_sec)
  );

  always #5 clk = ~clk;

  // Flags multi-hot spawns and play ticks outside PLAY.
  always @(negedge clk) begin
    if (!reset) begin
      if ($countones(spawn) > 1) mon_bad++;
      if (play_tick && state != 3'd2) mon_bad++;
    end
  end

  task automatic test_reset;
    int gap;
    reset = 1'b1;
    start_btn = 1'b0;
    pause_btn = 1'b0;
    hit = 4'd0;
    miss = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (state !== 3'd0) begin
      n_bad++;
      $display("FAIL rst_state got=%0d exp=0", state);
    end
    n_cmp++;
    if (lives_left !== 3'd5 || level !== 4'd0) begin
      n_bad++;
      $display("FAIL rst_lives_level got=%0d/%0d exp=5/0",
               lives_left, level);
    end
    n_cmp++;
    if (spawn_interval !== 8'd60) begin
      n_bad++;
      $display("FAIL rst_interval got=%0d exp=60", spawn_interval);
    end
    n_cmp++;
    if (spawn !== 4'd0 || frame_tick !== 1'b0 || play_tick !== 1'b0 ||
        game_active !== 1'b0 || countdown_sec !== 2'd0) begin
      n_bad++;
      $display("FAIL rst_outs got=%b%b%b%b%0d exp=0", spawn, frame_tick,
               play_tick, game_active, countdown_sec);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_tick) break;
    end
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      gap++;
      if (frame_tick) break;
    end
    n_cmp++;
    if (gap !== 4) begin
      n_bad++;
      $display("FAIL frame_period got=%0d exp=4", gap);
    end
    n_cmp++;
    if (state !== 3'd0) begin
      n_bad++;
      $display("FAIL idle_hold got=%0d exp=0", state);
    end
  endtask

  task automatic test_countdown;
    int entries = 0;
    int ticks = 0;
    int n3 = 0;
    int n2 = 0;
    int n1 = 0;
    int pt = 0;
    logic [2:0] prev;
    prev = state;
    start_btn = 1'b1;
    for (int c = 1; c < 2000; c++) begin
      @(negedge clk);
      if (c == 20) start_btn = 1'b0;
      if (state == 3'd1 && prev != 3'd1) entries++;
      if (play_tick && state != 3'd2) pt++;
      if (state == 3'd1 && frame_tick) begin
        ticks++;
        if (countdown_sec == 2'd3) n3++;
        if (countdown_sec == 2'd2) n2++;
        if (countdown_sec == 2'd1) n1++;
      end
      prev = state;
      if (state == 3'd2) break;
    end
    start_btn = 1'b0;
    n_cmp++;
    if (entries !== 1) begin
      n_bad++;
      $display("FAIL cd_entries got=%0d exp=1", entries);
    end
    n_cmp++;
    if (ticks !== 180) begin
      n_bad++;
      $display("FAIL cd_ticks got=%0d exp=180", ticks);
    end
    n_cmp++;
    if (n3 !== 60 || n2 !== 60 || n1 !== 60) begin
      n_bad++;
      $display("FAIL cd_digits got=%0d/%0d/%0d exp=60/60/60",
               n3, n2, n1);
    end
    n_cmp++;
    if (pt !== 0) begin
      n_bad++;
      $display("FAIL cd_play_tick got=%0d exp=0", pt);
    end
    n_cmp++;
    if (state !== 3'd2 || game_active !== 1'b1) begin
      n_bad++;
      $display("FAIL cd_to_play got=%0d/%b exp=2/1", state, game_active);
    end
  endtask

  task automatic test_spawn_cadence;
    logic [3:0] exp_l [3];
    logic [3:0] got;
    int ticks;
    exp_l[0] = 4'b0010;
    exp_l[1] = 4'b0100;
    exp_l[2] = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      ticks = 0;
      got = 4'd0;
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk);
        if (spawn != 4'd0) begin
          got = spawn;
          break;
        end
        if (frame_tick) ticks++;
      end
      n_cmp++;
      if (ticks !== 60) begin
        n_bad++;
        $display("FAIL spawn_gap%0d got=%0d exp=60", k, ticks);
      end
      n_cmp++;
      if (got !== exp_l[k]) begin
        n_bad++;
        $display("FAIL spawn_lane%0d got=%b exp=%b", k, got, exp_l[k]);
      end
      @(negedge clk);
      n_cmp++;
      if (spawn !== 4'd0) begin
        n_bad++;
        $display("FAIL spawn_width%0d got=%b exp=0000", k, spawn);
      end
    end
  endtask

  task automatic test_pause;
    int ticks = 0;
    int sp = 0;
    int pt = 0;
    int c = 0;
    logic [3:0] got;
    for (int i = 0; i < 1000 && ticks < 30; i++) begin
      @(negedge clk);
      if (frame_tick) ticks++;
    end
    pause_btn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (state !== 3'd3) begin
      n_bad++;
      $display("FAIL pause_enter got=%0d exp=3", state);
    end
    ticks = 0;
    while (ticks < 100 && c < 1000) begin
      @(negedge clk);
      c++;
      if (c == 3) hit = 4'b1111;
      if (c == 4) begin
        hit = 4'd0;
        miss = 4'b0011;
      end
      if (c == 5) begin
        miss = 4'd0;
        pause_btn = 1'b0;
      end
      if (frame_tick) ticks++;
      if (spawn != 4'd0) sp++;
      if (play_tick) pt++;
    end
    n_cmp++;
    if (sp !== 0 || pt !== 0) begin
      n_bad++;
      $display("FAIL pause_frozen got=%0d/%0d exp=0/0", sp, pt);
    end
    n_cmp++;
    if (state !== 3'd3 || lives_left !== 3'd5 || level !== 4'd0) begin
      n_bad++;
      $display("FAIL pause_ignore got=%0d/%0d/%0d exp=3/5/0",
               state, lives_left, level);
    end
    pause_btn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (state !== 3'd2) begin
      n_bad++;
      $display("FAIL pause_exit got=%0d exp=2", state);
    end
    ticks = 0;
    got = 4'd0;
    if (frame_tick) ticks++;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 2) pause_btn = 1'b0;
      if (spawn != 4'd0) begin
        got = spawn;
        break;
      end
      if (frame_tick) ticks++;
    end
    pause_btn = 1'b0;
    n_cmp++;
    if (ticks !== 30) begin
      n_bad++;
      $display("FAIL pause_resume_gap got=%0d exp=30", ticks);
    end
    n_cmp++;
    if (got !== 4'b0100) begin
      n_bad++;
      $display("FAIL pause_resume_lane got=%b exp=0100", got);
    end
  endtask

  task automatic test_level_ramp;
    int exp_i;
    int exp_l;
    for (int i = 0; i < 8; i++) begin
      hit = (i == 4) ? 4'b0011 : 4'b0001;
      @(negedge clk);
      hit = 4'd0;
      @(negedge clk);
    end
    n_cmp++;
    if (level !== 4'd0) begin
      n_bad++;
      $display("FAIL lvl_nine_hits got=%0d exp=0", level);
    end
    hit = 4'b0001;
    @(negedge clk);
    hit = 4'd0;
    n_cmp++;
    if (level !== 4'd1 || spawn_interval !== 8'd55) begin
      n_bad++;
      $display("FAIL lvl_first got=%0d/%0d exp=1/55",
               level, spawn_interval);
    end
    for (int lv = 2; lv <= 16; lv++) begin
      for (int h = 0; h < 10; h++) begin
        @(negedge clk);
        hit = 4'b1000;
        @(negedge clk);
        hit = 4'd0;
      end
      exp_i = (60 - 5 * lv < 20) ? 20 : 60 - 5 * lv;
      exp_l = (lv > 15) ? 15 : lv;
      n_cmp++;
      if (level !== 4'(exp_l) || spawn_interval !== 8'(exp_i)) begin
        n_bad++;
        $display("FAIL lvl_%0d got=%0d/%0d exp=%0d/%0d", lv, level,
                 spawn_interval, exp_l, exp_i);
      end
    end
  endtask

  task automatic test_lives_over;
    int ticks = 0;
    miss = 4'b0001;
    @(negedge clk);
    miss = 4'b0100;
    @(negedge clk);
    miss = 4'b1000;
    @(negedge clk);
    miss = 4'd0;
    n_cmp++;
    if (lives_left !== 3'd2 || state !== 3'd2) begin
      n_bad++;
      $display("FAIL lives_two got=%0d/%0d exp=2/2", lives_left, state);
    end
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (spawn != 4'd0) break;
    end
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        ticks++;
        if (ticks == 20) begin
          miss = 4'b0110;
          pause_btn = 1'b1;
          break;
        end
      end
    end
    @(negedge clk);
    miss = 4'd0;
    n_cmp++;
    if (state !== 3'd4 || lives_left !== 3'd0) begin
      n_bad++;
      $display("FAIL over_enter got=%0d/%0d exp=4/0", state, lives_left);
    end
    n_cmp++;
    if (spawn !== 4'd0 || game_active !== 1'b0) begin
      n_bad++;
      $display("FAIL over_no_spawn got=%b/%b exp=0000/0",
               spawn, game_active);
    end
    @(negedge clk);
    n_cmp++;
    if (state !== 3'd4 || spawn !== 4'd0) begin
      n_bad++;
      $display("FAIL over_hold got=%0d/%b exp=4/0000", state, spawn);
    end
    n_cmp++;
    if (level !== 4'd15 || spawn_interval !== 8'd20) begin
      n_bad++;
      $display("FAIL over_display got=%0d/%0d exp=15/20",
               level, spawn_interval);
    end
  endtask

  task automatic test_restart;
    pause_btn = 1'b0;
    @(negedge clk);
    start_btn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (state !== 3'd1 || lives_left !== 3'd5) begin
      n_bad++;
      $display("FAIL restart got=%0d/%0d exp=1/5", state, lives_left);
    end
    n_cmp++;
    if (level !== 4'd0 || spawn_interval !== 8'd60 ||
        countdown_sec !== 2'd3) begin
      n_bad++;
      $display("FAIL restart_vals got=%0d/%0d/%0d exp=0/60/3",
               level, spawn_interval, countdown_sec);
    end
    start_btn = 1'b0;
  endtask

  task automatic test_reset_mid_play;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (state == 3'd2) break;
    end
    for (int h = 0; h < 10; h++) begin
      hit = 4'b0100;
      @(negedge clk);
      hit = 4'd0;
      @(negedge clk);
    end
    n_cmp++;
    if (level !== 4'd1 || spawn_interval !== 8'd55) begin
      n_bad++;
      $display("FAIL mid_level got=%0d/%0d exp=1/55",
               level, spawn_interval);
    end
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (spawn != 4'd0) break;
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (spawn !== 4'd0 || state !== 3'd0) begin
      n_bad++;
      $display("FAIL async_rst got=%b/%0d exp=0000/0", spawn, state);
    end
    @(negedge clk);
    n_cmp++;
    if (lives_left !== 3'd5 || level !== 4'd0 ||
        spawn_interval !== 8'd60) begin
      n_bad++;
      $display("FAIL mid_rst_vals got=%0d/%0d/%0d exp=5/0/60",
               lives_left, level, spawn_interval);
    end
    n_cmp++;
    if (frame_tick !== 1'b0 || play_tick !== 1'b0 ||
        countdown_sec !== 2'd0 || game_active !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_rst_outs got=%b%b%0d%b exp=0000", frame_tick,
               play_tick, countdown_sec, game_active);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_invariants;
    n_cmp++;
    if (mon_bad !== 0) begin
      n_bad++;
      $display("FAIL invariants got=%0d exp=0", mon_bad);
    end
  endtask

  initial begin
    test_reset;
    test_countdown;
    test_spawn_cadence;
    test_pause;
    test_level_ramp;
    test_lives_over;
    test_restart;
    test_reset_mid_play;
    test_invariants;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
